// File: rtl/game_state_ctrl_pkg.sv
// Shared types and constants for the frog game state controller.
package game_state_ctrl_pkg;

  localparam int GRID_SIZE = 32;
  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HIT  = 2'd1,
    ST_WIN  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  // Advance the level, saturating at the last value a single digit can show.
  function automatic logic [3:0] level_next(input logic [3:0] level,
                                            input logic [3:0] level_max);
    return (level >= level_max) ? level_max : level + 4'd1;
  endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Position/event inputs and status outputs of the game state controller.
interface game_state_ctrl_if #(parameter int NUM_CARS = 2);

  logic                  i_Frame_Tick;
  logic                  i_Start;
  logic [9:0]            i_Frog_X;
  logic [9:0]            i_Frog_Y;
  logic [NUM_CARS*10-1:0] i_Car_X;
  logic [NUM_CARS*10-1:0] i_Car_Y;
  logic                  o_Frog_Reset;
  logic [3:0]            o_Level;
  logic [1:0]            o_Lives;
  logic [1:0]            o_State;
  logic                  o_Flash;
  logic                  o_Game_Over;

  // Upstream side: position generators and frame timing.
  modport master (
    output i_Frame_Tick, i_Start, i_Frog_X, i_Frog_Y, i_Car_X, i_Car_Y,
    input  o_Frog_Reset, o_Level, o_Lives, o_State, o_Flash, o_Game_Over
  );

  // Controller side.
  modport slave (
    input  i_Frame_Tick, i_Start, i_Frog_X, i_Frog_Y, i_Car_X, i_Car_Y,
    output o_Frog_Reset, o_Level, o_Lives, o_State, o_Flash, o_Game_Over
  );

endinterface

// File: rtl/game_state_ctrl_sprite_overlap.sv
// Axis-aligned overlap test of two square sprites given by their top-left corners.
// Edge-touching sprites do not overlap; 11-bit sums keep the test wrap-free.
module sprite_overlap #(
  parameter int GRID_SIZE = game_state_ctrl_pkg::GRID_SIZE
) (
  input  logic [9:0] a_x,
  input  logic [9:0] a_y,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  output logic       overlap
);

  localparam logic [10:0] EDGE = 11'(GRID_SIZE);

  logic [10:0] ax, ay, bx, by;

  assign ax = {1'b0, a_x};
  assign ay = {1'b0, a_y};
  assign bx = {1'b0, b_x};
  assign by = {1'b0, b_y};

  assign overlap = (ax < bx + EDGE) && (bx < ax + EDGE) &&
                   (ay < by + EDGE) && (by < ay + EDGE);

endmodule

// File: rtl/game_state_ctrl.sv
// Frame-rate game state machine: collision/goal detection, lives, level,
// hit/win hold timers and the frog-reset request.
module game_state_ctrl #(
  parameter int NUM_CARS   = 2,
  parameter int GRID_SIZE  = game_state_ctrl_pkg::GRID_SIZE,
  parameter int GOAL_Y     = 0,
  parameter int LIVES_INIT = 3,
  parameter int LEVEL_INIT = 1,
  parameter int LEVEL_MAX  = 9,
  parameter int HIT_FRAMES = 60,
  parameter int WIN_FRAMES = 30
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  game_state_ctrl_if.slave    bus
);

  import game_state_ctrl_pkg::*;

  localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] WIN_LAST   = 8'(WIN_FRAMES - 1);
  localparam logic [1:0] LIVES_RST  = 2'(LIVES_INIT);
  localparam logic [3:0] LEVEL_RST  = 4'(LEVEL_INIT);
  localparam logic [3:0] LEVEL_TOP  = 4'(LEVEL_MAX);
  localparam logic [9:0] GOAL_ROW   = 10'(GOAL_Y);

  state_t      state, state_n;
  logic [1:0]  lives, lives_n;
  logic [3:0]  level, level_n;
  logic [7:0]  cnt, cnt_n;
  logic        frog_reset_q, frog_reset_n;
  logic        flash_q, flash_n;
  logic        game_over_q, game_over_n;
  logic        reset_pend;

  logic [NUM_CARS-1:0] car_hit;
  logic                hit;
  logic                goal;

  for (genvar k = 0; k < NUM_CARS; k++) begin : g_car
    sprite_overlap #(.GRID_SIZE(GRID_SIZE)) u_overlap (
      .a_x     (bus.i_Frog_X),
      .a_y     (bus.i_Frog_Y),
      .b_x     (bus.i_Car_X[10*k +: 10]),
      .b_y     (bus.i_Car_Y[10*k +: 10]),
      .overlap (car_hit[k])
    );
  end

  assign hit  = |car_hit;
  assign goal = (bus.i_Frog_Y == GOAL_ROW);

  // State, counters and registered outputs; reset_pend remembers a reset just ended.
  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (i_Reset) begin
      state        <= ST_PLAY;
      lives        <= LIVES_RST;
      level        <= LEVEL_RST;
      cnt          <= '0;
      frog_reset_q <= 1'b0;
      flash_q      <= 1'b0;
      game_over_q  <= 1'b0;
      reset_pend   <= 1'b1;
    end else begin
      state        <= state_n;
      lives        <= lives_n;
      level        <= level_n;
      cnt          <= cnt_n;
      frog_reset_q <= frog_reset_n;
      flash_q      <= flash_n;
      game_over_q  <= game_over_n;
      reset_pend   <= 1'b0;
    end
  end

  // Next-state decode; events are only acted on in the frame-tick cycle.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_n      = state;
    lives_n      = lives;
    level_n      = level;
    cnt_n        = cnt;
    frog_reset_n = 1'b0;
    if (bus.i_Frame_Tick) begin
      case (state)
        ST_PLAY: begin
          if (hit) begin
            lives_n = lives - 2'd1;
            if (lives == 2'd1) begin
              state_n = ST_OVER;
            end else begin
              state_n = ST_HIT;
              cnt_n   = '0;
            end
          end else if (goal) begin
            state_n = ST_WIN;
            cnt_n   = '0;
          end
        end
        ST_HIT: begin
          if (cnt == HIT_LAST) begin
            state_n      = ST_PLAY;
            frog_reset_n = 1'b1;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        ST_WIN: begin
          if (cnt == WIN_LAST) begin
            state_n      = ST_PLAY;
            level_n      = level_next(level, LEVEL_TOP);
            frog_reset_n = 1'b1;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        ST_OVER: begin
          if (bus.i_Start) begin
            state_n      = ST_PLAY;
            lives_n      = LIVES_RST;
            level_n      = LEVEL_RST;
            frog_reset_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
    flash_n     = (state_n == ST_HIT) && cnt_n[0];
    game_over_n = (state_n == ST_OVER);
  end

  // The post-reset pulse is masked while reset is still held so it lands on
  // the first cycle after release only.
  assign bus.o_Frog_Reset = frog_reset_q | (reset_pend & ~i_Reset);
  assign bus.o_Level      = level;
  assign bus.o_Lives      = lives;
  assign bus.o_State      = state;
  assign bus.o_Flash      = flash_q;
  assign bus.o_Game_Over  = game_over_q;

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Sits directly downstream of the frog and car position generators and upstream of the VGA colour mux and seven-segment decoder.
- Once per frame, samples frog and car positions and detects frog/car overlap and goal-row arrival.
- Runs the play/hit/win/game-over state machine and owns the lives and level counters.
- Issues a one-cycle frog-reset request back to the frog movement logic.

Parameters:
- NUM_CARS, 2, number of car sprites checked.
- GRID_SIZE, 32, sprite edge in pixels (frog and cars are GRID_SIZE x GRID_SIZE).
- GOAL_Y, 0, frog_y value that counts as reaching the goal.
- LIVES_INIT, 3, lives at game start (1..3).
- LEVEL_INIT, 1, level at game start.
- LEVEL_MAX, 9, level saturation value (single seven-segment digit).
- HIT_FRAMES, 60, frames held in HIT.
- WIN_FRAMES, 30, frames held in WIN.

Ports:
- i_Clk  in  1  system/pixel clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Frame_Tick  in  1  one-cycle pulse at first vblank line; positions are stable while it is high.
- i_Start  in  1  level-sensitive restart request (OR of switches), used only in OVER.
- i_Frog_X  in  10  frog left edge, pixels.
- i_Frog_Y  in  10  frog top edge, pixels.
- i_Car_X  in  NUM_CARS*10  packed car left edges; car k is at bits [10k+9:10k].
- i_Car_Y  in  NUM_CARS*10  packed car top edges, same packing.
- o_Frog_Reset  out  1  one-cycle pulse: return frog to start cell.
- o_Level  out  4  current level, binary.
- o_Lives  out  2  remaining lives.
- o_State  out  2  0=PLAY, 1=HIT, 2=WIN, 3=OVER.
- o_Flash  out  1  high during HIT on odd frame counts; colour mux tints frog.
- o_Game_Over  out  1  high while in OVER.

Behaviour:
- Reset values: state PLAY, o_Lives=LIVES_INIT, o_Level=LEVEL_INIT, frame counter 0, o_Frog_Reset=0, o_Flash=0, o_Game_Over=0.
- Reset also forces o_Frog_Reset=1 for exactly the first cycle after reset deasserts, so the frog is aligned.
- Overlap for car k: {1'b0,Frog_X} < Car_X+GRID_SIZE AND Car_X < Frog_X+GRID_SIZE, and the same test on Y.
  - All sums are 11-bit; there is no wrap.
  - Edge-touching (difference == GRID_SIZE) is NOT a hit.
- hit = OR over all cars; goal = (i_Frog_Y == GOAL_Y).
- Both are evaluated combinationally and acted on only in the cycle i_Frame_Tick=1.
- Registered outputs change on the following edge: 1-cycle latency from the tick.
- PLAY on tick:
  - hit: decrement lives.
    - If lives was 1: lives=0, go to OVER.
    - Otherwise go to HIT and clear the frame counter.
  - else goal: go to WIN and clear the frame counter.
  - Simultaneous hit and goal: hit wins.
- HIT:
  - Frame counter increments on each tick.
  - o_Flash = counter[0] (registered); it is 0 outside HIT.
  - On the tick where counter == HIT_FRAMES-1: go to PLAY and pulse o_Frog_Reset for one cycle.
- WIN:
  - Counter runs as in HIT.
  - On the tick where counter == WIN_FRAMES-1: level = min(level+1, LEVEL_MAX), go to PLAY, pulse o_Frog_Reset.
  - Lives are unchanged.
- OVER:
  - o_Game_Over=1; hit and goal are ignored.
  - On the first tick with i_Start=1: lives=LIVES_INIT, level=LEVEL_INIT, go to PLAY, pulse o_Frog_Reset.
- Collisions are ignored outside PLAY (frog is frozen while its reset is pending).
- Frame ticks with no event leave all state unchanged.
- i_Reset has priority over every transition in the same cycle. Mid-HIT/WIN reset aborts cleanly to the reset values above.
- o_Frog_Reset is never high for two consecutive cycles.

Decomposition:
- Shared package holds:
  - state encoding constants (ST_PLAY=0, ST_HIT=1, ST_WIN=2, ST_OVER=3);
  - GRID_SIZE;
  - screen constants H_DISPLAY=640, V_DISPLAY=480.
- One sub-module, sprite_overlap: pure combinational AABB test on two 10-bit corner pairs with a GRID_SIZE parameter. It is instantiated NUM_CARS times via generate and the results are OR-reduced.
- The FSM, counters and output registers live in game_state_ctrl.

Test Plan:
- Reset, then Frog=(304,448), cars at (0,320),(100,384), 3 ticks -> o_Frog_Reset pulse once after reset; state stays 0, lives 3, level 1.
- Frog=(96,320), car0=(100,320), tick -> next cycle state=1, lives=2. After 60 ticks: state=0 and a single o_Frog_Reset pulse. o_Flash toggles per tick in between.
- Frog=(132,320), car0=(100,320) (touching), tick -> no hit, state 0.
- Frog_Y=0 with a car overlapping in the same tick -> HIT taken, not WIN, level unchanged. Separately, Frog_Y=0 alone -> WIN, level 2 after 30 ticks. With level preset to 9 via repeated wins -> stays 9.
- Three hits in succession -> lives 3→2→1→0; third hit enters OVER with o_Game_Over=1. Further hits are ignored. i_Start=1 plus tick -> lives 3, level 1, state 0, o_Frog_Reset pulse.
- Assert i_Reset at HIT frame 20 -> next cycle state 0, lives 3, o_Flash 0; post-reset frog reset pulse observed.
